scan_mux: RTL
=============

Name: scan_mux

Overview:
- Parametrised, registered N-channel, W-bit multiplexer.
- Replaces the fixed 8:1 single-bit combinational mux with a clocked block.
- Two modes:
  - Manual: external select.
  - Auto-scan: internal channel counter with programmable dwell.
- Sits between parallel sensor/data buses and a single serial consumer. Reports the active channel, a valid flag and a scan-wrap strobe.

Parameters:
- N_CH, 8, number of input channels (2..256, not necessarily a power of 2).
- DATA_W, 1, bits per channel.
- DWELL_W, 4, width of the dwell count input.
- SEL_W (localparam), clog2(N_CH), select/channel index width (minimum 1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  clock enable; low freezes all state.
- mode  input  1  0 = manual select, 1 = auto-scan.
- select  input  SEL_W  manual channel index.
- dwell  input  DWELL_W  auto-scan: each channel held for dwell+1 enabled cycles.
- in_x  input  N_CH*DATA_W  packed channels; channel i = in_x[i*DATA_W +: DATA_W].
- m_out  output  DATA_W  registered selected channel data.
- cur_sel  output  SEL_W  channel index that m_out currently reflects.
- out_valid  output  1  m_out holds legal channel data sampled on the last enabled edge.
- wrap  output  1  one-cycle pulse when auto-scan returns from channel N_CH-1 to 0.

Behaviour:
- Reset (rst=1 at an edge, overrides en): m_out=0, cur_sel=0, out_valid=0, wrap=0, dwell counter=0. Reset mid-scan gives cur_sel=0 on the next cycle.
- Each enabled edge computes next_sel combinationally, then registers cur_sel<=next_sel and m_out<=in_x slice of next_sel together. Latency is 1 cycle from select/in_x to m_out. cur_sel and m_out always describe the same channel.
- Manual mode (mode=0):
  - next_sel=select.
  - If select>=N_CH (non-power-of-2 N_CH only): cur_sel holds its previous value, m_out<=0, out_valid<=0.
  - Otherwise out_valid<=1.
  - Dwell counter is held at 0. wrap=0.
- Auto mode (mode=1):
  - Dwell counter cnt counts enabled cycles on the current channel.
  - If cnt<dwell: next_sel=cur_sel, cnt<=cnt+1.
  - Else: next_sel=(cur_sel==N_CH-1)?0:cur_sel+1, cnt<=0.
  - wrap<=1 exactly on the edge where cur_sel goes N_CH-1 -> 0; otherwise 0.
  - out_valid<=1.
  - dwell=0 advances one channel per enabled cycle.
  - dwell is compared live. A decrease below the current cnt ends the dwell on the next enabled edge; an increase extends the current dwell.
- Mode change:
  - Manual->auto: scan starts from the current cur_sel, with cnt=0 on the first auto edge. That edge counts as cycle 0 of the dwell, so it holds the current channel.
  - Auto->manual: select takes effect on the first manual edge and cnt is cleared.
- en=0:
  - cur_sel, m_out and cnt hold.
  - out_valid<=0 and wrap<=0.
  - On re-enable, the remaining dwell resumes; no cycles are lost or added.
- in_x changes while a channel dwells: m_out tracks the new data of the held channel on every enabled edge. This is a live mux, not a sample-and-hold.
- Simultaneous rst and en: rst wins.

Test Plan:
- Reset: rst=1 for 2 cycles with en=1, mode=1, in_x=8'hFF -> m_out=0, cur_sel=0, out_valid=0, wrap=0; first edge after release gives cur_sel=0, m_out=1.
- Manual sweep (N_CH=8, DATA_W=1): in_x=8'h4F, select 0..7, one per cycle -> m_out one cycle later = 1,1,1,1,0,0,1,0, out_valid=1 throughout; then in_x=8'h98, same sweep -> 0,0,0,1,1,0,0,1.
- Auto dwell=0: in_x=8'h98 -> cur_sel 0,1,..,7,0,1..; m_out 0,0,0,1,1,0,0,1 repeating; wrap high one cycle every 8 cycles, coincident with cur_sel=0.
- Auto dwell=2: each cur_sel value is held 3 cycles; wrap period is 24 cycles. Drop en for 5 cycles at cnt=1 -> cur_sel frozen, out_valid=0; after re-enable the channel is held for exactly 1 more cycle.
- N_CH=6, DATA_W=4, in_x=24'hFEDCBA: manual select=7 -> m_out=0, out_valid=0, cur_sel unchanged; select=5 -> m_out=4'hF; auto dwell=0 -> cur_sel wraps 5->0 with wrap pulse, period 6.
- Mode switch: auto at cur_sel=3 -> mode=0 with select=6 -> next cur_sel=6; then mode=1 with dwell=1 -> cur_sel 6,6,7,7,0(wrap),0.

Source files
------------

// File: rtl/scan_mux.sv
// scan_mux: registered N-channel W-bit mux with manual select or auto-scan with programmable dwell
module scan_mux #(
   parameter int N_CH = 8,
   parameter int DATA_W = 1,
   parameter int DWELL_W = 4,
   localparam int SEL_W = (N_CH > 2) ? $clog2(N_CH) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     mode,
   input  logic [SEL_W-1:0]         select,
   input  logic [DWELL_W-1:0]       dwell,
   input  logic [N_CH*DATA_W-1:0]   in_x,
   output logic [DATA_W-1:0]        m_out,
   output logic [SEL_W-1:0]         cur_sel,
   output logic                     out_valid,
   output logic                     wrap
);
   logic [DWELL_W-1:0] cnt;
   logic [SEL_W-1:0] next_sel;
   logic [DATA_W-1:0] data;
   logic sel_ok, adv, last;
   // next channel choice and the live data slice of that channel
   always_comb begin
      sel_ok = int'(select) < N_CH;
      last = cur_sel == SEL_W'(N_CH - 1);
      adv = cnt >= dwell;
      next_sel = mode ? (adv ? (last ? '0 : cur_sel + 1'b1) : cur_sel) : (sel_ok ? select : cur_sel);
      data = '0;
      for (int i = 0; i < N_CH; i++)
         if (next_sel == SEL_W'(i)) data = in_x[i*DATA_W +: DATA_W];
   end
   // channel, data, dwell counter and status registers; disabled cycles freeze state and drop the flags
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_sel <= '0;
         m_out <= '0;
         cnt <= '0;
         out_valid <= 1'b0;
         wrap <= 1'b0;
      end else if (en) begin
         cur_sel <= next_sel;
         m_out <= (mode || sel_ok) ? data : '0;
         cnt <= (mode && !adv) ? cnt + 1'b1 : '0;
         out_valid <= mode || sel_ok;
         wrap <= mode && adv && last;
      end else begin
         out_valid <= 1'b0;
         wrap <= 1'b0;
      end
   end
endmodule
